regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Multi-port integer register file with an integrated 1-bit-per-register scoreboard and optional write-to-read bypass. The issue stage marks destinations pending at allocation. Writeback ports commit data and clear pending. Read ports return the operand together with a ready flag. This block replaces the plain register file in the issue/operand-read stage of the core and adds hardwired-zero, flush and error reporting.

Parameters:
WIDTH, 64, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NREAD, 2, number of read ports
NWRITE, 2, number of write (writeback) ports
ZERO_REG, 1, 1 = register 0 reads zero, ignores writes/alloc, always ready
BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
alloc_valid  input  1  mark alloc_addr pending this cycle
alloc_addr  input  $clog2(NREGS)  destination register being allocated
we  input  NWRITE  per-port write enable
waddr  input  NWRITE x $clog2(NREGS)  per-port write address
wdata  input  NWRITE x WIDTH  per-port write data
raddr  input  NREAD x $clog2(NREGS)  per-port read address
rdata  output  NREAD x WIDTH  per-port read data (combinational)
rready  output  NREAD  operand valid this cycle (combinational)
flush  input  1  clear all pending bits
busy_count  output  $clog2(NREGS+1)  registered count of pending registers
wconflict_err  output  1  sticky: two enabled write ports hit the same address in one cycle
alloc_err  output  1  sticky: alloc to an already-pending register

Behaviour:
- Reset (rstn=0 at posedge): all regs=0, all pending=0, busy_count=0, wconflict_err=0, alloc_err=0. Applies mid-operation; same-cycle we/alloc/flush are ignored.
- Write commit at posedge: for each address, the lowest-index enabled port wins; the others are dropped. If ZERO_REG, writes to reg 0 are discarded.
- wconflict_err is set at the next posedge when >=2 enabled ports share an address, including address 0. It clears only on reset.
- Pending update per posedge, in priority order:
  - flush=1: all pending cleared; alloc that cycle ignored; write data still commits.
  - else alloc_valid with alloc_addr=A (A!=0 when ZERO_REG): pending[A] set. If a same-cycle write targets A, alloc wins and A stays pending; the data still commits.
  - else any enabled write to A clears pending[A].
- alloc_err is set when alloc_valid, no flush, and pending[A]=1 before the edge; pending[A] stays 1. Sticky until reset.
- Read (combinational, zero latency):
  - ZERO_REG and raddr=0: rdata=0, rready=1.
  - BYPASS=1 and an enabled write port targets raddr: rdata = wdata of the lowest-index matching port, rready=1.
  - else rdata = regs[raddr], rready = !pending[raddr].
  - BYPASS=0: rdata always comes from array state; rready=!pending. A write this cycle is visible next cycle.
- Same-cycle alloc to a register being read does not affect that cycle's rready. Pending changes take effect after the edge.
- busy_count = popcount(pending), registered, updated the same edge as pending. Never exceeds NREGS-ZERO_REG.
- Write to a non-pending register: data commits, pending stays 0, no error.

Test Plan:
- Reset then read: rstn=0 for 2 cycles, then raddr={5,0} -> rdata={0,0}, rready=2'b11, busy_count=0, both error flags 0.
- Alloc/writeback: alloc 7 at cycle0 -> cycle1 rready[0]=0 for raddr=7, busy_count=1. cycle1 we[1]=1, waddr=7, wdata=0xDEAD -> same cycle rdata=0xDEAD, rready=1 (bypass). Cycle2 from array: rdata=0xDEAD, rready=1, busy_count=0.
- Write priority/conflict: we=2'b11, both waddr=3, wdata={0x22 (port1), 0x11 (port0)} -> same-cycle bypass rdata=0x11. Next cycle regs[3]=0x11, wconflict_err=1, held until reset.
- Zero register: alloc 0 plus write 0 with 0xFF -> raddr=0 gives rdata=0, rready=1, busy_count unchanged.
- Flush/alloc race: pending {2,4,9}, busy_count=3; flush=1 with alloc 6 and write 9=0x5 -> next cycle busy_count=0, reg 6 ready, regs[9]=0x5.
- Double alloc and BYPASS=0 config: alloc 8 twice on consecutive cycles -> alloc_err=1, pending[8]=1. With BYPASS=0, write 8=0x3 -> same-cycle rready=0 and old data; next cycle rdata=0x3, rready=1.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : multi-port register file with per-register pending scoreboard
//              and optional same-cycle write-to-read bypass
// Revision   : 1.0
// ============================================================================
module regfile_sb #(
   parameter int WIDTH    = 64,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int NWRITE   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                                    clk,
   input  logic                                    rstn,
   input  logic                                    alloc_valid,
   input  logic [$clog2(NREGS)-1:0]                alloc_addr,
   input  logic [NWRITE-1:0]                       we,
   input  logic [NWRITE-1:0][$clog2(NREGS)-1:0]    waddr,
   input  logic [NWRITE-1:0][WIDTH-1:0]            wdata,
   input  logic [NREAD-1:0][$clog2(NREGS)-1:0]     raddr,
   output logic [NREAD-1:0][WIDTH-1:0]             rdata,
   output logic [NREAD-1:0]                        rready,
   input  logic                                    flush,
   output logic [$clog2(NREGS+1)-1:0]              busy_count,
   output logic                                    wconflict_err,
   output logic                                    alloc_err
);

   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(NREGS+1);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [NREGS-1:0] pending_q, pending_d;
   logic [CW-1:0]    busy_count_q, busy_count_d;
   logic             wconflict_err_q, wconflict_err_d;
   logic             alloc_err_q, alloc_err_d;
   logic             alloc_ok;

   assign alloc_ok = alloc_valid && !((ZERO_REG != 0) && (alloc_addr == '0));

   always_comb begin
      regs_d          = regs_q;
      pending_d       = pending_q;
      wconflict_err_d = wconflict_err_q;
      alloc_err_d     = alloc_err_q;
      busy_count_d    = '0;

      // Descending port order so the lowest-index enabled port lands last and wins.
      for (int p = NWRITE-1; p >= 0; p--) begin
         if (we[p] && !((ZERO_REG != 0) && (waddr[p] == '0))) begin
            regs_d[waddr[p]] = wdata[p];
         end
      end

      for (int i = 0; i < NWRITE; i++) begin
         for (int j = i+1; j < NWRITE; j++) begin
            if (we[i] && we[j] && (waddr[i] == waddr[j])) begin
               wconflict_err_d = 1'b1;
            end
         end
      end

      if (flush) begin
         pending_d = '0;
      end else begin
         for (int p = 0; p < NWRITE; p++) begin
            if (we[p]) begin
               pending_d[waddr[p]] = 1'b0;
            end
         end
         // Allocation is applied after writeback clears so a racing alloc keeps the bit set.
         if (alloc_ok) begin
            pending_d[alloc_addr] = 1'b1;
            if (pending_q[alloc_addr]) begin
               alloc_err_d = 1'b1;
            end
         end
      end

      for (int i = 0; i < NREGS; i++) begin
         busy_count_d = busy_count_d + {{(CW-1){1'b0}}, pending_d[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         regs_q          <= '{default: '0};
         pending_q       <= '0;
         busy_count_q    <= '0;
         wconflict_err_q <= 1'b0;
         alloc_err_q     <= 1'b0;
      end else begin
         regs_q          <= regs_d;
         pending_q       <= pending_d;
         busy_count_q    <= busy_count_d;
         wconflict_err_q <= wconflict_err_d;
         alloc_err_q     <= alloc_err_d;
      end
   end

   always_comb begin
      rdata  = '0;
      rready = '0;
      for (int r = 0; r < NREAD; r++) begin
         rdata[r]  = regs_q[raddr[r]];
         rready[r] = !pending_q[raddr[r]];
         if (BYPASS != 0) begin
            for (int p = NWRITE-1; p >= 0; p--) begin
               if (we[p] && (waddr[p] == raddr[r])) begin
                  rdata[r]  = wdata[p];
                  rready[r] = 1'b1;
               end
            end
         end
         if ((ZERO_REG != 0) && (raddr[r] == '0)) begin
            rdata[r]  = '0;
            rready[r] = 1'b1;
         end
      end
   end

   assign busy_count    = busy_count_q;
   assign wconflict_err = wconflict_err_q;
   assign alloc_err     = alloc_err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb : directed self-checking bench for regfile_sb (bypass and
//                 non-bypass instances driven by shared stimulus)
// Revision      : 1.0
// ============================================================================
module tb_regfile_sb;

   localparam int WIDTH  = 64;
   localparam int NREGS  = 32;
   localparam int NREAD  = 2;
   localparam int NWRITE = 2;
   localparam int AW     = $clog2(NREGS);
   localparam int CW     = $clog2(NREGS+1);

   logic                               clk;
   logic                               rstn;
   logic                               alloc_valid;
   logic [AW-1:0]                      alloc_addr;
   logic [NWRITE-1:0]                  we;
   logic [NWRITE-1:0][AW-1:0]          waddr;
   logic [NWRITE-1:0][WIDTH-1:0]       wdata;
   logic [NREAD-1:0][AW-1:0]           raddr;
   logic                               flush;

   logic [NREAD-1:0][WIDTH-1:0]        rdata,  rdata_nb;
   logic [NREAD-1:0]                   rready, rready_nb;
   logic [CW-1:0]                      busy_count, busy_count_nb;
   logic                               wconflict_err, wconflict_err_nb;
   logic                               alloc_err, alloc_err_nb;

   int total;
   int bad;

   regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE),
                .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rstn(rstn), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
      .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata),
      .rready(rready), .flush(flush), .busy_count(busy_count),
      .wconflict_err(wconflict_err), .alloc_err(alloc_err)
   );

   regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE),
                .ZERO_REG(1), .BYPASS(0)) dut_nb (
      .clk(clk), .rstn(rstn), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
      .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_nb),
      .rready(rready_nb), .flush(flush), .busy_count(busy_count_nb),
      .wconflict_err(wconflict_err_nb), .alloc_err(alloc_err_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid = 1'b0;
      alloc_addr  = '0;
      we          = '0;
      waddr       = '0;
      wdata       = '0;
      flush       = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle_inputs();
      raddr = '0;
      rstn  = 1'b0;

      // Reset, then read
      tick();
      tick();
      rstn     = 1'b1;
      raddr[0] = 5'd5;
      raddr[1] = 5'd0;
      #2;
      chk("rst_rdata0",   rdata[0], 64'd0);
      chk("rst_rdata1",   rdata[1], 64'd0);
      chk("rst_rready",   {62'd0, rready}, 64'd3);
      chk("rst_busy",     {58'd0, busy_count}, 64'd0);
      chk("rst_wconf",    {63'd0, wconflict_err}, 64'd0);
      chk("rst_aerr",     {63'd0, alloc_err}, 64'd0);

      // Allocate 7; same-cycle read is unaffected
      tick();
      alloc_valid = 1'b1;
      alloc_addr  = 5'd7;
      raddr[0]    = 5'd7;
      #2;
      chk("alloc_same_cycle_rready", {63'd0, rready[0]}, 64'd1);
      tick();
      idle_inputs();
      #2;
      chk("alloc7_rready",  {63'd0, rready[0]}, 64'd0);
      chk("alloc7_busy",    {58'd0, busy_count}, 64'd1);
      // Writeback on port 1 with bypass
      we[1]    = 1'b1;
      waddr[1] = 5'd7;
      wdata[1] = 64'hDEAD;
      #1;
      chk("wb7_bypass_rdata",  rdata[0], 64'hDEAD);
      chk("wb7_bypass_rready", {63'd0, rready[0]}, 64'd1);
      chk("wb7_nb_rready",     {63'd0, rready_nb[0]}, 64'd0);
      chk("wb7_nb_rdata",      rdata_nb[0], 64'd0);
      tick();
      idle_inputs();
      #2;
      chk("wb7_array_rdata",  rdata[0], 64'hDEAD);
      chk("wb7_array_rready", {63'd0, rready[0]}, 64'd1);
      chk("wb7_busy",         {58'd0, busy_count}, 64'd0);

      // Two ports write reg 3: port 0 wins
      we       = 2'b11;
      waddr[0] = 5'd3;
      waddr[1] = 5'd3;
      wdata[0] = 64'h11;
      wdata[1] = 64'h22;
      raddr[0] = 5'd3;
      #2;
      chk("conf_bypass_rdata", rdata[0], 64'h11);
      tick();
      idle_inputs();
      #2;
      chk("conf_array_rdata", rdata[0], 64'h11);
      chk("conf_wconf",       {63'd0, wconflict_err}, 64'd1);
      chk("conf_no_aerr",     {63'd0, alloc_err}, 64'd0);

      // Zero register ignores alloc and writes
      alloc_valid = 1'b1;
      alloc_addr  = 5'd0;
      we[0]       = 1'b1;
      waddr[0]    = 5'd0;
      wdata[0]    = 64'hFF;
      raddr[1]    = 5'd0;
      #2;
      chk("zero_same_rdata",  rdata[1], 64'd0);
      chk("zero_same_rready", {63'd0, rready[1]}, 64'd1);
      tick();
      idle_inputs();
      #2;
      chk("zero_rdata",  rdata[1], 64'd0);
      chk("zero_rready", {63'd0, rready[1]}, 64'd1);
      chk("zero_busy",   {58'd0, busy_count}, 64'd0);
      chk("zero_aerr",   {63'd0, alloc_err}, 64'd0);

      // Pending {2,4,9} then flush racing alloc 6 and write 9
      alloc_valid = 1'b1;
      alloc_addr  = 5'd2;
      tick();
      alloc_addr  = 5'd4;
      tick();
      alloc_addr  = 5'd9;
      tick();
      idle_inputs();
      #2;
      chk("pend3_busy", {58'd0, busy_count}, 64'd3);
      flush       = 1'b1;
      alloc_valid = 1'b1;
      alloc_addr  = 5'd6;
      we[0]       = 1'b1;
      waddr[0]    = 5'd9;
      wdata[0]    = 64'h5;
      tick();
      idle_inputs();
      raddr[0] = 5'd6;
      raddr[1] = 5'd9;
      #2;
      chk("flush_busy",    {58'd0, busy_count}, 64'd0);
      chk("flush_r6_rdy",  {63'd0, rready[0]}, 64'd1);
      chk("flush_r9_data", rdata[1], 64'h5);
      chk("flush_r9_rdy",  {63'd0, rready[1]}, 64'd1);
      chk("flush_aerr",    {63'd0, alloc_err}, 64'd0);

      // Double alloc of 8
      alloc_valid = 1'b1;
      alloc_addr  = 5'd8;
      raddr[0]    = 5'd8;
      tick();
      tick();
      idle_inputs();
      #2;
      chk("dbl_aerr",      {63'd0, alloc_err}, 64'd1);
      chk("dbl_aerr_nb",   {63'd0, alloc_err_nb}, 64'd1);
      chk("dbl_busy",      {58'd0, busy_count}, 64'd1);
      chk("dbl_rready",    {63'd0, rready[0]}, 64'd0);
      we[0]    = 1'b1;
      waddr[0] = 5'd8;
      wdata[0] = 64'h3;
      #1;
      chk("nb_same_rready", {63'd0, rready_nb[0]}, 64'd0);
      chk("nb_same_rdata",  rdata_nb[0], 64'd0);
      chk("byp_same_rdata", rdata[0], 64'h3);
      tick();
      idle_inputs();
      #2;
      chk("nb_next_rdata",  rdata_nb[0], 64'h3);
      chk("nb_next_rready", {63'd0, rready_nb[0]}, 64'd1);
      chk("nb_next_busy",   {58'd0, busy_count_nb}, 64'd0);
      chk("wconf_sticky",   {63'd0, wconflict_err}, 64'd1);
      chk("aerr_sticky",    {63'd0, alloc_err}, 64'd1);

      // Mid-operation reset drops the same-cycle alloc and write
      rstn        = 1'b0;
      alloc_valid = 1'b1;
      alloc_addr  = 5'd5;
      we[0]       = 1'b1;
      waddr[0]    = 5'd3;
      wdata[0]    = 64'h77;
      tick();
      rstn = 1'b1;
      idle_inputs();
      raddr[0] = 5'd3;
      raddr[1] = 5'd5;
      #2;
      chk("mrst_r3",    rdata[0], 64'd0);
      chk("mrst_r5rdy", {63'd0, rready[1]}, 64'd1);
      chk("mrst_busy",  {58'd0, busy_count}, 64'd0);
      chk("mrst_wconf", {63'd0, wconflict_err}, 64'd0);
      chk("mrst_aerr",  {63'd0, alloc_err}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
